// File: rtl/cmp_share_pkg.sv
// cmp_share_pkg: shared types and constants for the comparator-sharing arbiter.
package cmp_share_pkg;

    // Sequencer states: one operation in flight at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Latency counter width; holds OP_LAT-1 for OP_LAT up to 8.
    localparam int CNT_W = 3;

    // Width needed to hold an index in 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set request bit
// at or above PTR, wrapping modulo NREQ (NREQ need not be a power of two).
module rr_pick
    import cmp_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0] REQ_R,
    input  logic [ID_W-1:0] PTR,
    output logic            VLD,
    output logic [ID_W-1:0] ID
);

    // Walk NREQ positions starting at PTR; the first hit wins.
    always_comb begin
        int idx;
        idx = 0;
        VLD = 1'b0;
        ID  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(PTR) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!VLD && REQ_R[idx[ID_W-1:0]]) begin
                VLD = 1'b1;
                ID  = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: shares one registered two-operand comparator among NREQ
// requesters. Grants round-robin, latches the winner's operands, issues them,
// waits OP_LAT cycles and returns the result to the granted requester.
// Optional build macro CMP_SHARE_OPCHK_EN adds a sticky ERR output that is set
// (and the result dropped) when the operator's R_OUT is low at capture time.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int N      = 16,
    parameter int NREQ   = 4,
    parameter int OP_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [NREQ-1:0]   REQ_R,
    input  logic [NREQ*N-1:0] REQ_D1,
    input  logic [NREQ*N-1:0] REQ_D2,
    output logic [NREQ-1:0]   REQ_ACK,
    output logic              OP_R_IN,
    output logic [N-1:0]      OP_D_IN1,
    output logic [N-1:0]      OP_D_IN2,
    input  logic              OP_R_OUT,
    input  logic [N-1:0]      OP_D_OUT,
    output logic [NREQ-1:0]   RES_R,
    output logic [N-1:0]      RES_D,
`ifdef CMP_SHARE_OPCHK_EN
    output logic              ERR,
`endif
    output logic              BUSY
);

    localparam int               ID_W     = clog2(NREQ);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OP_LAT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);

    // Sequencer control
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  id_d;

    // Arbitration results
    logic             pick_vld;
    logic [ID_W-1:0]  pick_id;
    logic [NREQ-1:0]  pick_oh;
    logic [NREQ-1:0]  id_oh;
    logic [N-1:0]     pick_d1;
    logic [N-1:0]     pick_d2;

    // Next values of the registered outputs
    logic [NREQ-1:0]  ack_nx;
    logic             opr_nx;
    logic [N-1:0]     d1_nx;
    logic [N-1:0]     d2_nx;
    logic [NREQ-1:0]  resr_nx;
    logic [N-1:0]     resd_nx;
    logic             busy_nx;
`ifdef CMP_SHARE_OPCHK_EN
    logic             err_nx;
`else
    // Operator ready is not consulted without the check feature.
    logic             unused_op_r_out;
    assign unused_op_r_out = OP_R_OUT;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .REQ_R (REQ_R),
        .PTR   (ptr_q),
        .VLD   (pick_vld),
        .ID    (pick_id)
    );

    assign pick_oh = NREQ'(1) << pick_id;
    assign id_oh   = NREQ'(1) << id_q;

    // Select the winning requester's operand pair from the packed buses.
    always_comb begin
        pick_d1 = '0;
        pick_d2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                pick_d1 = REQ_D1[i*N +: N];
                pick_d2 = REQ_D2[i*N +: N];
            end
        end
    end

    // Next-state logic: everything holds while EN is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        if (EN) begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_d = ISSUE;
                        id_d    = pick_id;
                        ptr_d   = (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
                    end
                end
                ISSUE: begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter, pointer and owner-id registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

    // Output decode: pulse outputs last one enabled cycle; with EN low every
    // output register holds, which stretches any pulse in progress.
    always_comb begin
        ack_nx  = REQ_ACK;
        opr_nx  = OP_R_IN;
        d1_nx   = OP_D_IN1;
        d2_nx   = OP_D_IN2;
        resr_nx = RES_R;
        resd_nx = RES_D;
        busy_nx = BUSY;
`ifdef CMP_SHARE_OPCHK_EN
        err_nx  = ERR;
`endif
        if (EN) begin
            busy_nx = (state_d != IDLE);
            ack_nx  = '0;
            opr_nx  = 1'b0;
            resr_nx = '0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        ack_nx = pick_oh;
                        opr_nx = 1'b1;
                        d1_nx  = pick_d1;
                        d2_nx  = pick_d2;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
`ifdef CMP_SHARE_OPCHK_EN
                        if (!OP_R_OUT) begin
                            err_nx = 1'b1;
                        end else begin
                            resd_nx = OP_D_OUT;
                            resr_nx = id_oh;
                        end
`else
                        resd_nx = OP_D_OUT;
                        resr_nx = id_oh;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs; reset clears everything, dropping any in-flight result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            REQ_ACK  <= '0;
            OP_R_IN  <= 1'b0;
            OP_D_IN1 <= '0;
            OP_D_IN2 <= '0;
            RES_R    <= '0;
            RES_D    <= '0;
            BUSY     <= 1'b0;
`ifdef CMP_SHARE_OPCHK_EN
            ERR      <= 1'b0;
`endif
        end else begin
            REQ_ACK  <= ack_nx;
            OP_R_IN  <= opr_nx;
            OP_D_IN1 <= d1_nx;
            OP_D_IN2 <= d2_nx;
            RES_R    <= resr_nx;
            RES_D    <= resd_nx;
            BUSY     <= busy_nx;
`ifdef CMP_SHARE_OPCHK_EN
            ERR      <= err_nx;
`endif
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: scoreboard bench for cmp_share_arbiter with a
// registered BNE operator model (D_OUT = 1 when operands differ).
`timescale 1ns/1ps
module tb_cmp_share_arbiter;

    localparam int N      = 16;
    localparam int NREQ   = 4;
    localparam int OP_LAT = 1;

    logic              CLK = 1'b0;
    logic              RST;
    logic              EN;
    logic [NREQ-1:0]   REQ_R;
    logic [NREQ*N-1:0] REQ_D1;
    logic [NREQ*N-1:0] REQ_D2;
    logic [NREQ-1:0]   REQ_ACK;
    logic              OP_R_IN;
    logic [N-1:0]      OP_D_IN1;
    logic [N-1:0]      OP_D_IN2;
    logic              OP_R_OUT;
    logic [N-1:0]      OP_D_OUT;
    logic [NREQ-1:0]   RES_R;
    logic [N-1:0]      RES_D;
    logic              BUSY;
`ifdef CMP_SHARE_OPCHK_EN
    logic              ERR;
`endif
    logic              op_bad = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int           id;
        logic [N-1:0] d;
    } exp_t;

    exp_t res_q[$];
    int   ack_q[$];

    cmp_share_arbiter #(
        .N      (N),
        .NREQ   (NREQ),
        .OP_LAT (OP_LAT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .REQ_R    (REQ_R),
        .REQ_D1   (REQ_D1),
        .REQ_D2   (REQ_D2),
        .REQ_ACK  (REQ_ACK),
        .OP_R_IN  (OP_R_IN),
        .OP_D_IN1 (OP_D_IN1),
        .OP_D_IN2 (OP_D_IN2),
        .OP_R_OUT (OP_R_OUT),
        .OP_D_OUT (OP_D_OUT),
        .RES_R    (RES_R),
        .RES_D    (RES_D),
`ifdef CMP_SHARE_OPCHK_EN
        .ERR      (ERR),
`endif
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    // Operator model: registered BNE sharing the arbiter's EN
    always @(posedge CLK) begin
        if (RST) begin
            OP_D_OUT <= '0;
            OP_R_OUT <= 1'b0;
        end else if (EN) begin
            OP_D_OUT <= (OP_D_IN1 != OP_D_IN2) ? 16'd1 : 16'd0;
            OP_R_OUT <= OP_R_IN & ~op_bad;
        end
    end

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic logic [N-1:0] bne(input logic [N-1:0] a, input logic [N-1:0] b);
        return (a != b) ? 16'd1 : 16'd0;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        REQ_D1[i*N +: N] = a;
        REQ_D2[i*N +: N] = b;
    endtask

    // Record the grant and result the bench expects for requester i.
    task automatic expect_op(input int i);
        exp_t e;
        e.id = i;
        e.d  = bne(REQ_D1[i*N +: N], REQ_D2[i*N +: N]);
        ack_q.push_back(i);
        res_q.push_back(e);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1; REQ_R = '0; REQ_D1 = '0; REQ_D2 = '0;
        tick(); tick(); tick();
        n_chk++; if (REQ_ACK !== 4'b0000) $display("FAIL reset_ack got=%b want=0000", REQ_ACK); else n_pass++;
        n_chk++; if (OP_R_IN !== 1'b0) $display("FAIL reset_op_r_in got=%b want=0", OP_R_IN); else n_pass++;
        n_chk++; if (OP_D_IN1 !== 16'h0 || OP_D_IN2 !== 16'h0) $display("FAIL reset_op_d got=%h/%h want=0/0", OP_D_IN1, OP_D_IN2); else n_pass++;
        n_chk++; if (RES_R !== 4'b0000) $display("FAIL reset_res_r got=%b want=0000", RES_R); else n_pass++;
        n_chk++; if (RES_D !== 16'h0) $display("FAIL reset_res_d got=%h want=0", RES_D); else n_pass++;
        n_chk++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", BUSY); else n_pass++;
`ifdef CMP_SHARE_OPCHK_EN
        n_chk++; if (ERR !== 1'b0) $display("FAIL reset_err got=%b want=0", ERR); else n_pass++;
`endif
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        set_ops(2, 16'h1234, 16'h1234);
        expect_op(2);
        void'(ack_q.pop_front());
        REQ_R = 4'b0100;                               // C0
        tick();                                        // C1
        n_chk++; if (REQ_ACK !== 4'b0100) $display("FAIL single_ack got=%b want=0100", REQ_ACK); else n_pass++;
        n_chk++; if (OP_R_IN !== 1'b1) $display("FAIL single_op_r_in_c1 got=%b want=1", OP_R_IN); else n_pass++;
        n_chk++; if (OP_D_IN1 !== 16'h1234 || OP_D_IN2 !== 16'h1234) $display("FAIL single_op_d got=%h/%h want=1234/1234", OP_D_IN1, OP_D_IN2); else n_pass++;
        n_chk++; if (BUSY !== 1'b1) $display("FAIL single_busy_c1 got=%b want=1", BUSY); else n_pass++;
        REQ_R = '0;
        tick();                                        // C2
        n_chk++; if (REQ_ACK !== 4'b0000 || OP_R_IN !== 1'b0) $display("FAIL single_pulse_end got=%b/%b want=0000/0", REQ_ACK, OP_R_IN); else n_pass++;
        n_chk++; if (RES_R !== 4'b0000 || BUSY !== 1'b1) $display("FAIL single_c2 got res_r=%b busy=%b want=0000/1", RES_R, BUSY); else n_pass++;
        tick();                                        // C3
        e = res_q.pop_front();
        n_chk++; if (RES_R !== oh(e.id) || RES_D !== e.d) $display("FAIL single_result got=%b/%h want=%b/%h", RES_R, RES_D, oh(e.id), e.d); else n_pass++;
        n_chk++; if (BUSY !== 1'b1) $display("FAIL single_busy_c3 got=%b want=1", BUSY); else n_pass++;
        tick();                                        // C4
        n_chk++; if (RES_R !== 4'b0000 || BUSY !== 1'b0) $display("FAIL single_c4 got res_r=%b busy=%b want=0000/0", RES_R, BUSY); else n_pass++;
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   a;
        int   prev;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i), 16'h0);
        for (int g = 0; g < 5; g++) expect_op(g % NREQ);
        prev = -1;
        REQ_R = 4'b1111;
        for (int c = 0; c < 60 && res_q.size() > 0; c++) begin
            tick();
            if (REQ_ACK != 0) begin
                n_chk++;
                if (ack_q.size() == 0) $display("FAIL rr_extra_ack got=%b want=0000", REQ_ACK);
                else begin
                    a = ack_q.pop_front();
                    if (REQ_ACK !== oh(a)) $display("FAIL rr_ack got=%b want=%b", REQ_ACK, oh(a)); else n_pass++;
                end
                if (prev >= 0) begin
                    n_chk++; if (c - prev !== 4) $display("FAIL rr_spacing got=%0d want=4", c - prev); else n_pass++;
                end
                prev = c;
                if (ack_q.size() == 0) REQ_R = '0;
            end
            if (RES_R != 0) begin
                n_chk++;
                if (res_q.size() == 0) $display("FAIL rr_extra_res got=%b want=0000", RES_R);
                else begin
                    e = res_q.pop_front();
                    if (RES_R !== oh(e.id) || RES_D !== e.d) $display("FAIL rr_result got=%b/%h want=%b/%h", RES_R, RES_D, oh(e.id), e.d); else n_pass++;
                end
            end
        end
        n_chk++; if (res_q.size() != 0) $display("FAIL rr_timeout got=%0d pending want=0", res_q.size()); else n_pass++;
        res_q.delete(); ack_q.delete(); REQ_R = '0;
        tick();
    endtask

    task automatic test_ptr_wrap();
        exp_t e;
        int   a;
        set_ops(1, 16'd5, 16'd5);
        set_ops(3, 16'd7, 16'd8);
        set_ops(0, 16'd9, 16'd9);
        expect_op(1); expect_op(3); expect_op(0);
        REQ_R = 4'b0010;
        for (int c = 0; c < 60 && res_q.size() > 0; c++) begin
            tick();
            if (REQ_ACK != 0) begin
                n_chk++;
                if (ack_q.size() == 0) $display("FAIL wrap_extra_ack got=%b want=0000", REQ_ACK);
                else begin
                    a = ack_q.pop_front();
                    if (REQ_ACK !== oh(a)) $display("FAIL wrap_ack got=%b want=%b", REQ_ACK, oh(a)); else n_pass++;
                    if (ack_q.size() == 0) REQ_R = '0;
                    else if (a == 1) REQ_R = 4'b1001;
                end
            end
            if (RES_R != 0) begin
                n_chk++;
                if (res_q.size() == 0) $display("FAIL wrap_extra_res got=%b want=0000", RES_R);
                else begin
                    e = res_q.pop_front();
                    if (RES_R !== oh(e.id) || RES_D !== e.d) $display("FAIL wrap_result got=%b/%h want=%b/%h", RES_R, RES_D, oh(e.id), e.d); else n_pass++;
                end
            end
        end
        n_chk++; if (res_q.size() != 0) $display("FAIL wrap_timeout got=%0d pending want=0", res_q.size()); else n_pass++;
        res_q.delete(); ack_q.delete(); REQ_R = '0;
        tick();
    endtask

    task automatic test_en_stall();
        exp_t e;
        set_ops(1, 16'd3, 16'd4);
        expect_op(1);
        void'(ack_q.pop_front());
        REQ_R = 4'b0010;                               // C0
        tick();                                        // C1
        n_chk++; if (REQ_ACK !== 4'b0010) $display("FAIL stall_ack got=%b want=0010", REQ_ACK); else n_pass++;
        REQ_R = '0; EN = 1'b0;
        tick();                                        // C2: ISSUE frozen
        n_chk++; if (REQ_ACK !== 4'b0010 || OP_R_IN !== 1'b1) $display("FAIL stall_ack_stretch got=%b/%b want=0010/1", REQ_ACK, OP_R_IN); else n_pass++;
        EN = 1'b1;
        tick();                                        // C3: WAIT
        n_chk++; if (REQ_ACK !== 4'b0000 || OP_R_IN !== 1'b0) $display("FAIL stall_issue_end got=%b/%b want=0000/0", REQ_ACK, OP_R_IN); else n_pass++;
        EN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (RES_R !== 4'b0000 || BUSY !== 1'b1) $display("FAIL stall_hold%0d got res_r=%b busy=%b want=0000/1", k, RES_R, BUSY); else n_pass++;
        end
        EN = 1'b1;
        tick();
        e = res_q.pop_front();
        n_chk++; if (RES_R !== oh(e.id) || RES_D !== e.d) $display("FAIL stall_result got=%b/%h want=%b/%h", RES_R, RES_D, oh(e.id), e.d); else n_pass++;
        tick();
        n_chk++; if (RES_R !== 4'b0000) $display("FAIL stall_dup got=%b want=0000", RES_R); else n_pass++;
        tick();
        n_chk++; if (RES_R !== 4'b0000 || BUSY !== 1'b0) $display("FAIL stall_idle got res_r=%b busy=%b want=0000/0", RES_R, BUSY); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   a;
        set_ops(2, 16'd1, 16'd2);
        REQ_R = 4'b0100;                               // C0
        tick();                                        // C1
        n_chk++; if (REQ_ACK !== 4'b0100) $display("FAIL rmid_ack got=%b want=0100", REQ_ACK); else n_pass++;
        REQ_R = '0;
        tick();                                        // C2: WAIT
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_chk++; if (REQ_ACK !== 4'b0000 || OP_R_IN !== 1'b0 || BUSY !== 1'b0) $display("FAIL rmid_ctrl got=%b/%b/%b want=0000/0/0", REQ_ACK, OP_R_IN, BUSY); else n_pass++;
        n_chk++; if (OP_D_IN1 !== 16'h0 || OP_D_IN2 !== 16'h0) $display("FAIL rmid_op_d got=%h/%h want=0/0", OP_D_IN1, OP_D_IN2); else n_pass++;
        n_chk++; if (RES_R !== 4'b0000 || RES_D !== 16'h0) $display("FAIL rmid_res got=%b/%h want=0000/0", RES_R, RES_D); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (RES_R !== 4'b0000) $display("FAIL rmid_dropped%0d got=%b want=0000", k, RES_R); else n_pass++;
        end
        set_ops(2, 16'd5, 16'd5);
        set_ops(3, 16'd6, 16'd7);
        expect_op(2);
        REQ_R = 4'b1100;
        for (int c = 0; c < 20 && res_q.size() > 0; c++) begin
            tick();
            if (REQ_ACK != 0) begin
                n_chk++;
                if (ack_q.size() == 0) $display("FAIL rmid_extra_ack got=%b want=0000", REQ_ACK);
                else begin
                    a = ack_q.pop_front();
                    if (REQ_ACK !== oh(a)) $display("FAIL rmid_ptr_ack got=%b want=%b", REQ_ACK, oh(a)); else n_pass++;
                end
                REQ_R = '0;
            end
            if (RES_R != 0) begin
                n_chk++;
                if (res_q.size() == 0) $display("FAIL rmid_extra_res got=%b want=0000", RES_R);
                else begin
                    e = res_q.pop_front();
                    if (RES_R !== oh(e.id) || RES_D !== e.d) $display("FAIL rmid_result got=%b/%h want=%b/%h", RES_R, RES_D, oh(e.id), e.d); else n_pass++;
                end
            end
        end
        n_chk++; if (res_q.size() != 0) $display("FAIL rmid_timeout got=%0d pending want=0", res_q.size()); else n_pass++;
        res_q.delete(); ack_q.delete(); REQ_R = '0;
        tick();
    endtask

`ifdef CMP_SHARE_OPCHK_EN
    task automatic test_err();
        exp_t e;
        op_bad = 1'b1;
        set_ops(3, 16'd1, 16'd2);
        REQ_R = 4'b1000;
        tick();
        n_chk++; if (REQ_ACK !== 4'b1000) $display("FAIL err_ack got=%b want=1000", REQ_ACK); else n_pass++;
        REQ_R = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_chk++; if (RES_R !== 4'b0000) $display("FAIL err_suppress%0d got=%b want=0000", k, RES_R); else n_pass++;
        end
        n_chk++; if (ERR !== 1'b1 || BUSY !== 1'b0) $display("FAIL err_set got=%b/%b want=1/0", ERR, BUSY); else n_pass++;
        op_bad = 1'b0;
        set_ops(0, 16'd4, 16'd5);
        expect_op(0);
        void'(ack_q.pop_front());
        REQ_R = 4'b0001;
        tick();
        n_chk++; if (REQ_ACK !== 4'b0001) $display("FAIL err_next_ack got=%b want=0001", REQ_ACK); else n_pass++;
        REQ_R = '0;
        tick(); tick();
        e = res_q.pop_front();
        n_chk++; if (RES_R !== oh(e.id) || RES_D !== e.d) $display("FAIL err_next_result got=%b/%h want=%b/%h", RES_R, RES_D, oh(e.id), e.d); else n_pass++;
        n_chk++; if (ERR !== 1'b1) $display("FAIL err_sticky got=%b want=1", ERR); else n_pass++;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_en_stall();
        test_reset_mid();
`ifdef CMP_SHARE_OPCHK_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
